load_store_unit: RTL and testbench
==================================

# load_store_unit

Bridges the CPU memory stage to the word-addressed, byte-enabled data memory (synchronous read, per-byte write enables). Accepts one load/store request at a time over a valid/ready handshake and generates byte enables and lane-replicated store data. Absorbs the memory's one-cycle read latency, then sign- or zero-extends load data. Every request returns exactly one response, held until accepted; misaligned accesses are flagged and never reach memory.

## Interface
- No parameters. Data and address widths are fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads (ignored for word and stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_rd  in  5  destination tag, returned unchanged
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_rd  out  5  tag of the request
- rsp_err  out  1  misaligned or illegal-size request
- mem_we  out  4  byte write enables to data memory
- mem_addr  out  30  word address (byte address [31:2])
- mem_din  out  32  store data to memory
- mem_dout  in  32  memory read data, valid the cycle after mem_addr is presented

## Operation
- States: IDLE, LOAD, RESP. Reset state is IDLE.
- req_ready = (state == IDLE) && !rst.
- Misalignment is checked on acceptance:
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - size 11
  - Error case: mem_we stays 0, the response register is loaded with err = 1, rdata = 0, tag; state goes to RESP.
- Aligned store on acceptance, combinationally in the same cycle:
  - mem_addr = req_addr[31:2]
  - byte: mem_we = 0001 << addr[1:0]; mem_din = {4{wdata[7:0]}}
  - half: mem_we = 0011 << addr[1:0]; mem_din = {2{wdata[15:0]}}
  - word: mem_we = 1111; mem_din = wdata
  - Response register loaded with err = 0, rdata = 0; state goes to RESP.
- Aligned load on acceptance:
  - mem_addr = req_addr[31:2] and mem_we = 0.
  - addr[1:0], size, unsigned and rd are latched; state goes to LOAD.
- LOAD (one cycle):
  - mem_dout is shifted right by 8 × addr[1:0], then sign- or zero-extended from bit 7 or bit 15.
  - The result is captured into rsp_rdata; state goes to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_rdata, rsp_rd and rsp_err are held stable until rsp_ready.
  - When rsp_ready is high, state goes to IDLE.
- mem_we is nonzero only in the accepted-store cycle. It is 0 in LOAD, RESP, IDLE without acceptance, and whenever rst is high.
- mem_addr outside an acceptance cycle holds the last latched word address. It has no functional effect.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_rd 0, rsp_err 0, mem_we 0, mem_din 0, latched address 0.
- Store accepted in cycle N: memory written at the end of N; rsp_valid from N+1.
- Load accepted in cycle N: mem_dout sampled in N+1; rsp_valid from N+2.
- Error accepted in cycle N: rsp_valid from N+1.
- Throughput: with rsp_ready held high, one store per 2 cycles and one load per 3 cycles.
- No new request is accepted in the same cycle as a response handshake.
- rst high in any state: next cycle is IDLE with rsp_valid 0. A pending response is discarded and no memory write occurs.
- rsp_ready while rsp_valid = 0 is ignored.
- req_* inputs may change freely when req_ready = 0.

## Structure
- lsu_pkg holds:
  - SIZE_BYTE/HALF/WORD encodings
  - state enum (IDLE, LOAD, RESP)
  - byte-enable base constants
- Sub-module lsu_align (combinational):
  - store lane replication and byte-enable generation
  - load shift/extend
  - misalignment detection
- load_store_unit holds the FSM, latches and response register.

## Test plan
- sw 0xDEADBEEF @0x10, then lw @0x10
  - store: mem_we = 1111, rsp_valid one cycle after acceptance, rsp_err = 0
  - load: rsp_rdata = 0xDEADBEEF two cycles after acceptance
- sb wdata 0x5A @0x13
  - mem_we = 1000, mem_din = 0x5A5A5A5A
  - following lw @0x10 returns 0x5AADBEEF
- Memory word 0x80018080 @0x20:
  - lb @0x20 → 0xFFFFFF80
  - lbu @0x20 → 0x00000080
  - lh @0x22 → 0xFFFF8001
  - lhu @0x22 → 0x00008001
- Misaligned accesses:
  - lw @0x12 → rsp_err = 1, rdata 0, one-cycle latency
  - sh @0x11 and size 11 → rsp_err = 1
  - mem_we = 0 throughout; a later lw @0x10 confirms memory is unchanged
- Backpressure: rsp_ready low for 3 cycles
  - rsp_valid and rsp_rdata/rsp_rd/rsp_err stay stable; req_ready = 0
  - rsp_ready high → IDLE next cycle; the next request is accepted then
- rst pulsed during LOAD, and during a store-acceptance cycle
  - next cycle: rsp_valid = 0, state IDLE
  - no write during the rst cycle
  - req_ready = 1 after rst deasserts

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store unit
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication, byte enables, load extend, alignment check
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  output logic        misaligned,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    misaligned = 1'b0;
    st_be      = 4'b0000;
    st_data    = 32'd0;
    case (req_size)
      SIZE_BYTE: begin
        st_be   = BE_BYTE << req_off;
        st_data = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        misaligned = req_off[0];
        st_be      = BE_HALF << req_off;
        st_data    = {2{req_wdata[15:0]}};
      end
      SIZE_WORD: begin
        misaligned = (req_off != 2'b00);
        st_be      = BE_WORD;
        st_data    = req_wdata;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Bring the addressed byte/half down to bit 0 before extending.
  assign ld_shifted = ld_raw >> {ld_off, 3'b000};

  always_comb begin
    ld_data = ld_raw;
    case (ld_size)
      SIZE_BYTE: ld_data = {{24{ld_shifted[7] & ~ld_unsigned}}, ld_shifted[7:0]};
      SIZE_HALF: ld_data = {{16{ld_shifted[15] & ~ld_unsigned}}, ld_shifted[15:0]};
      default:   ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU memory-stage bridge to a byte-enabled synchronous data memory
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  lsu_state_e  state;
  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [29:0] addr_q;

  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic        misaligned;
  logic [31:0] ld_data;
  logic        accept;
  logic        accept_store;

  lsu_align u_align (
    .req_size    (req_size),
    .req_off     (req_addr[1:0]),
    .req_wdata   (req_wdata),
    .st_be       (st_be),
    .st_data     (st_data),
    .misaligned  (misaligned),
    .ld_size     (ld_size),
    .ld_off      (ld_off),
    .ld_unsigned (ld_unsigned),
    .ld_raw      (mem_dout),
    .ld_data     (ld_data)
  );

  assign req_ready    = (state == IDLE) && !rst;
  assign accept       = req_valid && req_ready;
  // Stores write combinationally in the accepting cycle; req_ready already masks rst.
  assign accept_store = accept && req_we && !misaligned;
  assign mem_we       = accept_store ? st_be : 4'b0000;
  assign mem_din      = accept_store ? st_data : 32'd0;
  assign mem_addr     = accept ? req_addr[31:2] : addr_q;
  assign rsp_valid    = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rsp_rdata   <= 32'd0;
      rsp_rd      <= 5'd0;
      rsp_err     <= 1'b0;
      addr_q      <= 30'd0;
      ld_off      <= 2'b00;
      ld_size     <= SIZE_BYTE;
      ld_unsigned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= req_addr[31:2];
            rsp_rd    <= req_rd;
            rsp_rdata <= 32'd0;
            rsp_err   <= misaligned;
            if (misaligned || req_we) begin
              state <= RESP;
            end else begin
              ld_off      <= req_addr[1:0];
              ld_size     <= req_size;
              ld_unsigned <= req_unsigned;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          rsp_rdata <= ld_data;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench against a byte-level memory model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_rd       (rsp_rd),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  // Data memory: synchronous read, per-byte write enables.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) mem[mem_addr[3:0]][8*i +: 8] <= mem_din[8*i +: 8];
    mem_dout <= mem[mem_addr[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int hold);
    int          nb;
    int          off;
    int          idx;
    int          lat;
    int          waitc;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_din;
    logic [31:0] exp_rdata;
    logic [31:0] v;

    off     = int'(addr[1:0]);
    idx     = int'(addr[5:2]);
    nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exp_err = (size == 2'd3) || (nb == 2 && (off % 2) != 0) || (nb == 4 && off != 0);
    exp_be  = 4'b0000;
    exp_din = 32'd0;
    exp_rdata = 32'd0;

    if (!exp_err && we) begin
      for (int i = 0; i < 4; i++) begin
        exp_din = exp_din | (((wdata >> (8 * (i % nb))) & 32'hFF) << (8 * i));
        if (i >= off && i < off + nb) exp_be[i] = 1'b1;
      end
    end else if (!exp_err) begin
      v = ref_mem[idx] >> (8 * off);
      if (nb == 1) begin
        exp_rdata = v & 32'hFF;
        if (!uns && v[7]) exp_rdata = exp_rdata | 32'hFFFF_FF00;
      end else if (nb == 2) begin
        exp_rdata = v & 32'hFFFF;
        if (!uns && v[15]) exp_rdata = exp_rdata | 32'hFFFF_0000;
      end else begin
        exp_rdata = ref_mem[idx];
      end
    end

    rsp_ready    = (hold == 0);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    #1;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    chk("mem_we", 32'(mem_we), 32'(exp_be));
    if (!exp_err) chk("mem_addr", 32'(mem_addr), 32'(addr[31:2]));
    if (!exp_err && we) chk("mem_din", mem_din, exp_din);

    for (int i = 0; i < 4; i++)
      if (exp_be[i]) ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * i))) | (exp_din & (32'hFF << (8 * i)));

    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_rd       = 5'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      chk("mem_we_idle", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), (exp_err || we) ? 32'd1 : 32'd2);
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_rd", 32'(rsp_rd), 32'(rd));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      chk("mem_we_resp", 32'(mem_we), 32'd0);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("req_ready_post_rst", 32'(req_ready), 32'd1);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd2, 0);
    chk("sw_lw_value", ref_mem[4], 32'hDEADBEEF);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h5A, 5'd3, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd4, 0);
    chk("sb_model", ref_mem[4], 32'h5AADBEEF);
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h80018080, 5'd5, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 5'd6, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 5'd7, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 5'd8, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 5'd9, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 5'd10, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 5'd11, 0);
    do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF, 5'd12, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd13, 3);

    // Reset while a load is outstanding.
    do_req(1'b1, 2'd2, 1'b0, 32'h18, 32'hCAFEF00D, 5'd14, 0);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h18; req_rd = 5'd15;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_load_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    chk("rst_load_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_load_req_ready", 32'(req_ready), 32'd1);

    // Reset in the cycle a store is presented: no write may occur.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h18; req_wdata = 32'h11111111;
    rst = 1'b1;
    #1;
    chk("rst_store_req_ready", 32'(req_ready), 32'd0);
    chk("rst_store_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_store_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_store_req_ready_after", 32'(req_ready), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h18, 32'h0, 5'd16, 0);

    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 63)),
             $urandom, 5'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
